// File: rtl/mult_div_ctrl_if.sv
// Handshake and data bundle for the signed multiply/divide controller.
//   master: drives ctrl_MULT, ctrl_DIV, operandA, operandB; observes results.
//   slave : the controller; drives result, exception, resultRDY, busy.
interface mult_div_ctrl_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [31:0] result;
  logic        exception;
  logic        resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, operandA, operandB,
    input  result, exception, resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, operandA, operandB,
    output result, exception, resultRDY, busy
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative 32-bit signed multiply / divide controller.
// One shift-add (multiply) or restoring (divide) step per cycle on operand
// magnitudes, sign applied at completion.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   bus.slave : ctrl_MULT/ctrl_DIV start strobes, operandA/operandB inputs,
//               result/exception/resultRDY/busy outputs (all registered)
module mult_div_ctrl (
  input  logic            clock,
  input  logic            reset,
  mult_div_ctrl_if.slave  bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] ITERS = CW'(W);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  prod_q, prod_d;   // mult: {acc, multiplier}; div: {rem, quotient}
  logic [W-1:0]    mcand_q, mcand_d; // |multiplicand| or |divisor|
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;     // most-negative / -1 divide
  logic [W-1:0]    result_q, result_d;
  logic            exc_q, exc_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;

  logic            start;
  logic [W:0]      add_sum;
  logic [W:0]      trial;
  logic            ge;
  logic [2*W-1:0]  prod_fin;
  logic [W-1:0]    quo_fin;

  function automatic logic [W-1:0] abs32(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
  // Multiply step: conditionally add multiplicand into the upper half.
  assign add_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : (W+1)'(0));
  // Divide step: shift next dividend bit into the partial remainder.
  assign trial    = {prod_q[2*W-1:W], prod_q[W-1]};
  assign ge       = trial >= {1'b0, mcand_q};
  assign prod_fin = neg_q ? (~prod_q + (2*W)'(1)) : prod_q;
  assign quo_fin  = neg_q ? (~prod_q[W-1:0] + W'(1)) : prod_q[W-1:0];

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;

    if (start) begin
      // A start in any state aborts and restarts; multiply wins a tie.
      state_d  = bus.ctrl_MULT ? MULT : DIV;
      cnt_d    = '0;
      neg_d    = bus.operandA[W-1] ^ bus.operandB[W-1];
      result_d = '0;
      exc_d    = 1'b0;
      busy_d   = 1'b1;
      if (bus.ctrl_MULT) begin
        prod_d  = {W'(0), abs32(bus.operandB)};
        mcand_d = abs32(bus.operandA);
        ovf_d   = 1'b0;
      end else begin
        prod_d  = {W'(0), abs32(bus.operandA)};
        mcand_d = abs32(bus.operandB);
        ovf_d   = (bus.operandA == 32'h8000_0000) && (bus.operandB == 32'hFFFF_FFFF);
      end
    end else begin
      case (state_q)
        MULT: begin
          if (cnt_q == ITERS) begin
            state_d  = DONE;
            result_d = prod_fin[W-1:0];
            // Overflow unless bits 63:31 are a pure sign extension.
            exc_d    = ~((&prod_fin[2*W-1:W-1]) | ~(|prod_fin[2*W-1:W-1]));
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end else begin
            prod_d = {add_sum, prod_q[W-1:1]};
            cnt_d  = cnt_q + CW'(1);
          end
        end
        DIV: begin
          if (mcand_q == '0) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end else if (cnt_q == ITERS) begin
            state_d  = DONE;
            result_d = quo_fin;
            exc_d    = ovf_q;
            rdy_d    = 1'b1;
            busy_d   = 1'b0;
          end else begin
            prod_d = {ge ? (trial[W-1:0] - mcand_q) : trial[W-1:0],
                      prod_q[W-2:0], ge};
            cnt_d  = cnt_q + CW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.exception = exc_q;
  assign bus.resultRDY = rdy_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl with hand-computed expected values.
module tb_mult_div_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  mult_div_ctrl_if bus ();

  mult_div_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation, wait for completion (bounded) and check everything.
  task automatic run_op(input string tag, input logic is_mult, input logic is_div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc,
                        input int exp_lat);
    int lat;
    int busy_cnt;
    logic [31:0] held;
    @(posedge clock); #1;
    bus.ctrl_MULT = is_mult;
    bus.ctrl_DIV  = is_div;
    bus.operandA  = a;
    bus.operandB  = b;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.operandA  = $urandom;
    bus.operandB  = $urandom;
    check({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    check({tag, "_res_run"}, bus.result, 32'd0);
    lat = 0;
    busy_cnt = 1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (bus.resultRDY) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busycnt"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_res"}, bus.result, exp_res);
    check({tag, "_exc"}, 32'(bus.exception), 32'(exp_exc));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    held = bus.result;
    @(posedge clock); #1;
    check({tag, "_rdy_1cyc"}, 32'(bus.resultRDY), 32'd0);
    check({tag, "_hold"}, bus.result, exp_res);
    check({tag, "_hold_exc"}, 32'(bus.exception), 32'(exp_exc));
    if (held !== exp_res) check({tag, "_held_mid"}, held, exp_res);
  endtask

  initial begin
    int pulses;
    int first_lat;
    logic [31:0] rdy_res;

    // Reset wins over a simultaneous start.
    reset         = 1'b1;
    bus.ctrl_MULT = 1'b1;
    bus.ctrl_DIV  = 1'b0;
    bus.operandA  = 32'd3;
    bus.operandB  = 32'd4;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdy", 32'(bus.resultRDY), 32'd0);
    check("rst_res", bus.result, 32'd0);
    check("rst_exc", 32'(bus.exception), 32'd0);
    bus.ctrl_MULT = 1'b0;
    reset         = 1'b0;

    run_op("mul_7_m3",   1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mul_ovf1",   1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33);
    run_op("mul_ovf2",   1, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 33);
    run_op("mul_minx1",  1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33);
    run_op("mul_neg2",   1, 0, 32'hFFFF_FFFA,  32'hFFFF_FFF9, 32'd42,        1'b0, 33);
    run_op("div_m7_2",   0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_100_7",  0, 1, 32'd100,        32'd7,         32'd14,        1'b0, 33);
    run_op("div_by0",    0, 1, 32'd5,          32'd0,         32'd0,         1'b1, 1);
    run_op("div_min_m1", 0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
    run_op("both_6_3",   1, 1, 32'd6,          32'd3,         32'd18,        1'b0, 33);

    // Restart: divide aborted by a multiply 10 cycles later.
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b1;
    bus.operandA = 32'd9;
    bus.operandB = 32'd3;
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock); #1;
      if (bus.resultRDY) pulses++;
    end
    bus.ctrl_MULT = 1'b1;
    bus.operandA  = 32'd4;
    bus.operandB  = 32'd5;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    first_lat = 0;
    rdy_res   = 32'hDEAD_BEEF;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clock); #1;
      if (bus.resultRDY) begin
        pulses++;
        if (first_lat == 0) begin
          first_lat = i;
          rdy_res   = bus.result;
        end
      end
    end
    check("restart_pulses", 32'(pulses), 32'd1);
    check("restart_lat", 32'(first_lat), 32'd33);
    check("restart_res", rdy_res, 32'd20);

    // Reset mid-operation: no completion afterwards, outputs zero.
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b1;
    bus.operandA  = 32'd7;
    bus.operandB  = 32'hFFFF_FFFD;
    @(posedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_res", bus.result, 32'd0);
    check("midrst_exc", 32'(bus.exception), 32'd0);
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (bus.resultRDY || bus.busy) pulses++;
    end
    check("midrst_no_rdy", 32'(pulses), 32'd0);
    check("midrst_res_end", bus.result, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
